uart_rx: RTL and testbench

Serial receiver that consumes the 8N1 bit stream produced by the `uart` transmitter and returns parallel bytes. It sits directly downstream of the transmitter, either on the board's RX pin or looped back from TX in simulation. It shares the transmitter's `bdiv` bit-period convention and presents received bytes through a one-entry holding register with a valid/read handshake.

---
 rtl/uart_rx.sv | 120 ++++++++++++
 tb/tb_uart_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 serial receiver: two-flop input synchronizer, mid-bit sampling FSM driven
// by a run-time bit divisor, and a one-entry holding register with sticky flags.
module uart_rx (
  input  logic        clk,
  input  logic        reset,
  input  logic        rxd,
  input  logic [15:0] bdiv,
  input  logic        re,
  output logic [7:0]  rdata,
  output logic        valid,
  output logic        ferr,
  output logic        oerr,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t      state;
  logic [1:0]  sync;
  logic        rxs;
  logic [15:0] cnt;
  logic [2:0]  bitn;
  logic [7:0]  sh;
  logic        cnt_z;

  assign rxs   = sync[1];
  assign cnt_z = (cnt == 16'd0);

  // Idle-high reset value so release on a quiet line never looks like a start edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync <= 2'b11;
    else        sync <= {sync[0], rxd};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 16'd0;
      bitn  <= 3'd0;
      sh    <= 8'h00;
      rdata <= 8'h00;
      valid <= 1'b0;
      ferr  <= 1'b0;
      oerr  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      // Read clears first; a frame finishing this same edge overrides below.
      if (re) begin
        valid <= 1'b0;
        ferr  <= 1'b0;
        oerr  <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= {1'b0, bdiv[15:1]};
            state <= START;
            busy  <= 1'b1;
          end
        end
        START: begin
          if (!cnt_z) begin
            cnt <= cnt - 16'd1;
          end else if (!rxs) begin
            cnt   <= bdiv;
            bitn  <= 3'd0;
            state <= DATA;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DATA: begin
          if (!cnt_z) begin
            cnt <= cnt - 16'd1;
          end else begin
            sh  <= {rxs, sh[7:1]};
            cnt <= bdiv;
            if (bitn == 3'd7) state <= STOP;
            else              bitn  <= bitn + 3'd1;
          end
        end
        STOP: begin
          if (!cnt_z) begin
            cnt <= cnt - 16'd1;
          end else if (rxs) begin
            if (!valid || re) begin
              rdata <= sh;
              valid <= 1'b1;
            end else begin
              oerr <= 1'b1;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            ferr  <= 1'b1;
            state <= BRK;
          end
        end
        BRK: begin
          if (rxs) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an 8N1 line driver feeds rxd, tasks check each scenario.
module tb_uart_rx;

  logic        clk;
  logic        reset;
  logic        rxd;
  logic [15:0] bdiv;
  logic        re;
  logic [7:0]  rdata;
  logic        valid;
  logic        ferr;
  logic        oerr;
  logic        busy;

  int vectors;
  int miscompares;

  uart_rx dut (
    .clk   (clk),
    .reset (reset),
    .rxd   (rxd),
    .bdiv  (bdiv),
    .re    (re),
    .rdata (rdata),
    .valid (valid),
    .ferr  (ferr),
    .oerr  (oerr),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Transmitter-side bit period: bdiv+1 cycles, matching the receiver's counter.
  task automatic tx_bit(input logic b);
    rxd = b;
    repeat (int'(bdiv) + 1) @(posedge clk);
  endtask

  task automatic tx_byte(input logic [7:0] d);
    tx_bit(1'b0);
    for (int k = 0; k < 8; k++) tx_bit(d[k]);
    tx_bit(1'b1);
  endtask

  task automatic pulse_re;
    @(negedge clk) re = 1'b1;
    @(negedge clk) re = 1'b0;
  endtask

  task automatic wait_valid(input int budget);
    for (int i = 0; i < budget && !valid; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    rxd   = 1'b1;
    re    = 1'b0;
    bdiv  = 16'd20;
    repeat (3) @(posedge clk);
    #1;
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    vectors++; if (valid !== 1'b0)  begin miscompares++; $display("FAIL reset_valid got=%b exp=0", valid); end
    vectors++; if (ferr  !== 1'b0)  begin miscompares++; $display("FAIL reset_ferr got=%b exp=0", ferr); end
    vectors++; if (oerr  !== 1'b0)  begin miscompares++; $display("FAIL reset_oerr got=%b exp=0", oerr); end
    vectors++; if (busy  !== 1'b0)  begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk) reset = 1'b1;
    repeat (5) @(posedge clk);
  endtask

  // Expected valid edge: 2 sync + 1 IDLE + (217+1) start + 9*(434+1) = 4136 cycles.
  task automatic test_loopback;
    int lat;
    bit got;
    bdiv = 16'd434;
    repeat (4) @(posedge clk);
    lat = 0;
    got = 1'b0;
    fork
      tx_byte(8'h41);
      begin
        for (int i = 1; i <= 5000 && !got; i++) begin
          @(posedge clk); #1;
          if (valid) begin got = 1'b1; lat = i; end
        end
      end
    join
    vectors++; if (got !== 1'b1)  begin miscompares++; $display("FAIL loop_valid got=%b exp=1", got); end
    vectors++; if (lat < 4134 || lat > 4138) begin miscompares++; $display("FAIL loop_latency got=%0d exp=4136", lat); end
    vectors++; if (rdata !== 8'h41) begin miscompares++; $display("FAIL loop_rdata got=%h exp=41", rdata); end
    vectors++; if (ferr !== 1'b0 || oerr !== 1'b0) begin miscompares++; $display("FAIL loop_flags got=%b%b exp=00", ferr, oerr); end
    pulse_re;
    #1;
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL loop_re_clear got=%b exp=0", valid); end
    bdiv = 16'd20;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_back_to_back;
    logic [7:0] exp [2];
    exp[0] = 8'h55;
    exp[1] = 8'hAA;
    fork
      begin
        tx_byte(8'h55);
        tx_byte(8'hAA);
      end
      begin
        for (int n = 0; n < 2; n++) begin
          wait_valid(400);
          vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid%0d got=%b exp=1", n, valid); end
          vectors++; if (rdata !== exp[n]) begin miscompares++; $display("FAIL b2b_rdata%0d got=%h exp=%h", n, rdata, exp[n]); end
          vectors++; if (ferr !== 1'b0 || oerr !== 1'b0) begin miscompares++; $display("FAIL b2b_flags%0d got=%b%b exp=00", n, ferr, oerr); end
          pulse_re;
        end
      end
    join
    repeat (4) @(posedge clk);
  endtask

  task automatic test_framing;
    logic [7:0] d;
    d = 8'h41;
    tx_bit(1'b0);
    for (int k = 0; k < 8; k++) tx_bit(d[k]);
    repeat (3) tx_bit(1'b0);
    #1;
    vectors++; if (ferr  !== 1'b1) begin miscompares++; $display("FAIL ferr_set got=%b exp=1", ferr); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL ferr_valid got=%b exp=0", valid); end
    vectors++; if (busy  !== 1'b1) begin miscompares++; $display("FAIL ferr_busy_break got=%b exp=1", busy); end
    rxd = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ferr_busy_release got=%b exp=0", busy); end
    pulse_re;
    #1;
    vectors++; if (ferr !== 1'b0) begin miscompares++; $display("FAIL ferr_re_clear got=%b exp=0", ferr); end
    tx_byte(8'h42);
    #1;
    vectors++; if (valid !== 1'b1 || rdata !== 8'h42) begin miscompares++; $display("FAIL ferr_next got=%b/%h exp=1/42", valid, rdata); end
    vectors++; if (ferr !== 1'b0) begin miscompares++; $display("FAIL ferr_next_flag got=%b exp=0", ferr); end
    pulse_re;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_overrun;
    tx_byte(8'h11);
    tx_byte(8'h22);
    #1;
    vectors++; if (rdata !== 8'h11) begin miscompares++; $display("FAIL ovr_rdata got=%h exp=11", rdata); end
    vectors++; if (oerr  !== 1'b1)  begin miscompares++; $display("FAIL ovr_oerr got=%b exp=1", oerr); end
    vectors++; if (valid !== 1'b1)  begin miscompares++; $display("FAIL ovr_valid got=%b exp=1", valid); end
    pulse_re;
    #1;
    vectors++; if (valid !== 1'b0 || oerr !== 1'b0) begin miscompares++; $display("FAIL ovr_re_clear got=%b%b exp=00", valid, oerr); end
    repeat (4) @(posedge clk);
  endtask

  task automatic test_glitch;
    bit saw_busy;
    bdiv = 16'd16;
    repeat (4) @(posedge clk);
    saw_busy = 1'b0;
    @(posedge clk) rxd = 1'b0;
    repeat (3) @(posedge clk);
    rxd = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) saw_busy = 1'b1;
    end
    vectors++; if (saw_busy !== 1'b1) begin miscompares++; $display("FAIL glitch_seen got=%b exp=1", saw_busy); end
    vectors++; if (busy !== 1'b0)  begin miscompares++; $display("FAIL glitch_idle got=%b exp=0", busy); end
    vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL glitch_valid got=%b exp=0", valid); end
    vectors++; if (ferr !== 1'b0 || oerr !== 1'b0) begin miscompares++; $display("FAIL glitch_flags got=%b%b exp=00", ferr, oerr); end
    bdiv = 16'd20;
    repeat (4) @(posedge clk);
  endtask

  task automatic test_midframe_reset;
    logic [7:0] d;
    d = 8'h41;
    tx_byte(8'h33);
    #1;
    vectors++; if (valid !== 1'b1 || rdata !== 8'h33) begin miscompares++; $display("FAIL mrst_pre got=%b/%h exp=1/33", valid, rdata); end
    tx_bit(1'b0);
    for (int k = 0; k < 3; k++) tx_bit(d[k]);
    rxd = d[3];
    repeat ((int'(bdiv) + 1) / 2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL mrst_busy_pre got=%b exp=1", busy); end
    #3 reset = 1'b0;
    #1;
    vectors++; if (rdata !== 8'h00) begin miscompares++; $display("FAIL mrst_rdata got=%h exp=00", rdata); end
    vectors++; if (valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mrst_valid_busy got=%b%b exp=00", valid, busy); end
    vectors++; if (ferr !== 1'b0 || oerr !== 1'b0) begin miscompares++; $display("FAIL mrst_flags got=%b%b exp=00", ferr, oerr); end
    rxd = 1'b1;
    repeat (3 * (int'(bdiv) + 1)) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    repeat (2 * (int'(bdiv) + 1)) @(posedge clk);
    tx_byte(8'h41);
    #1;
    vectors++; if (valid !== 1'b1 || rdata !== 8'h41) begin miscompares++; $display("FAIL mrst_next got=%b/%h exp=1/41", valid, rdata); end
    vectors++; if (ferr !== 1'b0 || oerr !== 1'b0) begin miscompares++; $display("FAIL mrst_next_flags got=%b%b exp=00", ferr, oerr); end
    pulse_re;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset;
    test_loopback;
    test_back_to_back;
    test_framing;
    test_overrun;
    test_glitch;
    test_midframe_reset;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
